aes_i2c_ctrl: RTL and testbench

//  Frame sequencer between the I2C slave byte interface and the AES-128 core.
//  - Assembles a 33-byte write frame: 16 key bytes, 16 data bytes (MSB first), then 1 command byte.
//  - Starts the core, waits for completion with a timeout, and holds the 128-bit result for readback.
//  - Sole owner of the AES core start/mode inputs.

---
 rtl/aes_i2c_ctrl.sv | 145 ++++++++++++++
 tb/tb_aes_i2c_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_i2c_ctrl.sv
// rtl/aes_i2c_ctrl.sv - frame sequencer between the I2C slave byte interface and the AES-128 core
// Collects key/data/command bytes, launches the core, and holds the result or an error code.

module aes_i2c_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_start,
    input  logic         rx_stop,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    output logic [127:0] aes_key,
    output logic [127:0] aes_block,
    output logic         aes_decrypt,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_result,
    output logic [127:0] result,
    output logic         result_valid,
    output logic         busy,
    output logic         err,
    output logic [1:0]   err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_KEY,
        S_RX_DATA,
        S_RX_CMD,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_FRAME   = 2'b01;
    localparam logic [1:0] ERR_CMD     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [5:0]      byte_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [6:0]      byte_pos;

    // Frame byte 0 lands in bits [127:120], so the bit offset is 8*(15-idx).
    assign byte_pos = {~byte_cnt[3:0], 3'b000};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            to_cnt       <= '0;
            aes_key      <= '0;
            aes_block    <= '0;
            aes_decrypt  <= 1'b0;
            aes_start    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            err_code     <= '0;
        end else begin
            aes_start <= 1'b0;
            case (state)
                // The core is never aborted: start/stop are ignored until it finishes.
                S_RUN: begin
                    if (rx_valid) begin
                        err      <= 1'b1;
                        err_code <= ERR_FRAME;
                    end
                    if (aes_done) begin
                        result       <= aes_result;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        busy     <= 1'b0;
                        state    <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_start) begin
                        state        <= S_RX_KEY;
                        byte_cnt     <= '0;
                        err          <= 1'b0;
                        err_code     <= '0;
                        result_valid <= 1'b0;
                    end else begin
                        case (state)
                            S_RX_KEY, S_RX_DATA: begin
                                if (rx_valid) begin
                                    if (state == S_RX_KEY) aes_key[byte_pos +: 8] <= rx_byte;
                                    else                   aes_block[byte_pos +: 8] <= rx_byte;
                                    byte_cnt <= byte_cnt + 1'b1;
                                    if (byte_cnt == 6'd15) state <= S_RX_DATA;
                                    if (byte_cnt == 6'd31) state <= S_RX_CMD;
                                end
                                // A byte arriving with STOP is consumed first; the frame is still short.
                                if (rx_stop) begin
                                    state    <= S_ERR;
                                    err      <= 1'b1;
                                    err_code <= ERR_FRAME;
                                end
                            end
                            S_RX_CMD: begin
                                if (rx_valid) begin
                                    if (rx_byte[7:1] == 7'd0) begin
                                        aes_decrypt <= rx_byte[0];
                                        aes_start   <= 1'b1;
                                        busy        <= 1'b1;
                                        to_cnt      <= '0;
                                        state       <= S_RUN;
                                    end else begin
                                        state    <= S_ERR;
                                        err      <= 1'b1;
                                        err_code <= ERR_CMD;
                                    end
                                end else if (rx_stop) begin
                                    state    <= S_ERR;
                                    err      <= 1'b1;
                                    err_code <= ERR_FRAME;
                                end
                            end
                            S_DONE: begin
                                if (rx_valid) begin
                                    state    <= S_ERR;
                                    err      <= 1'b1;
                                    err_code <= ERR_FRAME;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_i2c_ctrl.sv
// tb/tb_aes_i2c_ctrl.sv - randomized self-checking bench for aes_i2c_ctrl
// A transaction-level frame model predicts every output each cycle; a stand-in core answers aes_start.

module tb_aes_i2c_ctrl;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         rx_start = 1'b0;
    logic         rx_stop = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_byte = '0;
    logic [127:0] aes_key;
    logic [127:0] aes_block;
    logic         aes_decrypt;
    logic         aes_start;
    logic         aes_done = 1'b0;
    logic [127:0] aes_result = '0;
    logic [127:0] result;
    logic         result_valid;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;

    aes_i2c_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
        .clk(clk), .reset(reset),
        .rx_start(rx_start), .rx_stop(rx_stop), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .aes_key(aes_key), .aes_block(aes_block), .aes_decrypt(aes_decrypt),
        .aes_start(aes_start), .aes_done(aes_done), .aes_result(aes_result),
        .result(result), .result_valid(result_valid), .busy(busy),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] d, input logic dec);
        return dec ? (k ^ {d[63:0], d[127:64]}) : (k + d);
    endfunction

    // Reference model: frame bytes, run age and expected outputs.
    logic [7:0]   m_key_b [16];
    logic [7:0]   m_blk_b [16];
    logic         m_dec, m_start, m_busy, m_rv, m_err;
    logic [1:0]   m_code;
    logic [127:0] m_result;
    bit           recv, running, finished;
    int           nbytes, age;

    // Stand-in core.
    int           core_lat = 10;
    int           core_cnt = 0;
    logic [127:0] core_res = '0;

    function automatic logic [127:0] pack(input bit blk);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = blk ? m_blk_b[i] : m_key_b[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_key_b[i] = '0;
            m_blk_b[i] = '0;
        end
        m_dec = 0; m_start = 0; m_busy = 0; m_rv = 0; m_err = 0; m_code = 0; m_result = '0;
        recv = 0; running = 0; finished = 0; nbytes = 0; age = 0;
    endtask

    task automatic model_update(input bit rn, input bit st, input bit sp, input bit v,
                                input logic [7:0] b, input bit done);
        if (!rn) begin
            model_reset();
            return;
        end
        m_start = 0;
        if (running) begin
            age++;
            if (v) begin m_err = 1; m_code = 2'b01; end
            if (done) begin
                m_result = fake_aes(pack(0), pack(1), m_dec);
                m_rv = 1; m_busy = 0; running = 0; finished = 1;
            end else if (age == TO) begin
                m_err = 1; m_code = 2'b11; m_busy = 0; running = 0;
            end
        end else if (st) begin
            recv = 1; nbytes = 0; m_err = 0; m_code = 0; m_rv = 0; finished = 0;
        end else if (recv) begin
            if (v) begin
                nbytes++;
                if (nbytes <= 16) m_key_b[nbytes-1] = b;
                else if (nbytes <= 32) m_blk_b[nbytes-17] = b;
                else begin
                    recv = 0;
                    if (b <= 8'd1) begin
                        m_dec = b[0]; m_start = 1; m_busy = 1; running = 1; age = 0;
                    end else begin
                        m_err = 1; m_code = 2'b10;
                    end
                end
            end
            if (recv && sp) begin recv = 0; m_err = 1; m_code = 2'b01; end
        end else if (finished && v) begin
            finished = 0; m_err = 1; m_code = 2'b01;
        end
    endtask

    task automatic step(input bit rn, input bit st, input bit sp, input bit v, input logic [7:0] b);
        @(negedge clk);
        reset = rn; rx_start = st; rx_stop = sp; rx_valid = v; rx_byte = b;
        aes_done = (core_cnt == 1);
        aes_result = aes_done ? core_res : {$urandom, $urandom, $urandom, $urandom};
        if (!aes_done && !running && rn && $urandom_range(0, 29) == 0) aes_done = 1'b1;
        @(posedge clk);
        model_update(rn, st, sp, v, b, aes_done);
        #1;
        check("aes_key", aes_key, pack(0));
        check("aes_block", aes_block, pack(1));
        check("aes_decrypt", aes_decrypt, m_dec);
        check("aes_start", aes_start, m_start);
        check("busy", busy, m_busy);
        check("result", result, m_result);
        check("result_valid", result_valid, m_rv);
        check("err", err, m_err);
        check("err_code", err_code, m_code);
        if (!rn) core_cnt = 0;
        else if (core_cnt > 0) core_cnt--;
        if (aes_start && core_lat > 0) begin
            core_cnt = core_lat;
            core_res = fake_aes(aes_key, aes_block, aes_decrypt);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 8'h00);
    endtask

    task automatic send(input logic [7:0] q[$], input bit stop_last);
        for (int i = 0; i < q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            step(1, 0, stop_last && (i == q.size() - 1), 1, q[i]);
        end
    endtask

    task automatic frame(input logic [127:0] k, input logic [127:0] d, input logic [7:0] cmd,
                         input int len, input bit stop_last);
        logic [7:0] q[$];
        for (int i = 0; i < 16; i++) q.push_back(k[127-8*i -: 8]);
        for (int i = 0; i < 16; i++) q.push_back(d[127-8*i -: 8]);
        q.push_back(cmd);
        while (q.size() > len) void'(q.pop_back());
        step(1, 1, 0, 0, 8'h00);
        send(q, stop_last);
    endtask

    localparam logic [127:0] K  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D  = 128'h0123456789abcdef0123456789abcdef;
    localparam logic [127:0] K2 = 128'hfedcba98765432100f1e2d3c4b5a6978;

    initial begin
        model_reset();
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 1, 1, 8'hff);

        frame(K, D, 8'h00, 33, 0); idle(15);          // encrypt
        frame(K, D, 8'h01, 33, 0); idle(15);          // decrypt
        frame(K, D, 8'h5a, 33, 0); idle(5);           // bad command
        frame(K, D, 8'h00, 20, 0); step(1, 0, 1, 0, 8'h00); idle(3);
        frame(K, D, 8'h00, 33, 0); idle(15);
        core_lat = 0;
        frame(K2, D, 8'h00, 33, 0); idle(22);         // timeout
        core_lat = 10;
        frame(D, D, 8'h00, 10, 0);                    // repeated START mid-frame
        frame(K2, ~D, 8'h01, 33, 0); idle(15);
        frame(K, ~D, 8'h00, 33, 1); idle(15);         // 33rd byte with STOP
        frame(K, D, 8'h01, 32, 1); idle(3);           // missing command byte
        frame(K2, D, 8'h00, 33, 0); idle(2);
        step(1, 1, 0, 1, 8'h44); step(1, 0, 1, 0, 8'h00); idle(14);
        step(1, 0, 0, 1, 8'h99); idle(2);             // extra byte after DONE
        step(1, 1, 0, 1, 8'h77); step(1, 0, 1, 0, 8'h00);
        frame(K, D, 8'h00, 33, 0); idle(3);
        step(0, 0, 0, 0, 8'h00); idle(12);            // reset mid-RUN

        for (int it = 0; it < 60; it++) begin
            int len;
            logic [7:0] cmd;
            core_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 20));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34)) : 33;
            case ($urandom_range(0, 3))
                0: cmd = 8'h00;
                1: cmd = 8'h01;
                2: cmd = 8'h00;
                default: cmd = 8'($urandom);
            endcase
            frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  cmd, (len > 33) ? 33 : len, $urandom_range(0, 7) == 0);
            for (int c = 0; c < int'($urandom_range(2, 24)); c++) begin
                case ($urandom_range(0, 19))
                    0: step(1, 0, 0, 1, 8'($urandom));
                    1: step(1, 1, 0, 0, 8'h00);
                    2: step(1, 0, 1, 0, 8'h00);
                    default: step(1, 0, 0, 0, 8'h00);
                endcase
            end
            if ($urandom_range(0, 9) == 0) step(0, 0, 0, 0, 8'h00);
        end
        idle(25);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
